// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving an 8:1 bit-select mux with registered output
// Grants are held up to MAX_HOLD cycles or until the holder drops its request.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [7:0]       x,
  output logic [7:0]       gnt,
  output logic [2:0]       sel,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             y,
  output logic             y_valid
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_gnt, w_gnt_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic             r_y, r_y_valid;

  logic [2:0]       w_win;
  logic [2:0]       w_idx;
  logic             w_found;
  logic             w_release;

  // Scan ptr+1 .. ptr+8 (mod 8) so the last holder is the final candidate.
  always_comb begin
    w_win   = 3'd0;
    w_found = 1'b0;
    w_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_release = !req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_sel_nxt       = r_sel;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_gnt_valid_nxt = r_gnt_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = 8'd1 << w_win;
          w_sel_nxt       = w_win;
          w_ptr_nxt       = w_win;
          w_cnt_nxt       = CNT_W'(1);
          w_gnt_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!w_release) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_found) begin
          w_gnt_nxt       = 8'd1 << w_win;
          w_sel_nxt       = w_win;
          w_ptr_nxt       = w_win;
          w_cnt_nxt       = CNT_W'(1);
          w_gnt_valid_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_gnt_nxt       = 8'd0;
          w_cnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_nxt       = 8'd0;
        w_cnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 8'd0;
      r_sel       <= 3'd0;
      r_ptr       <= 3'd7;
      r_cnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_y         <= 1'b0;
      r_y_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      // Datapath uses the grant registered before this edge, so y lags gnt by one cycle.
      r_y         <= r_gnt_valid ? x[r_sel] : 1'b0;
      r_y_valid   <= r_gnt_valid;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_gnt_valid;
  assign hold_cnt  = r_cnt;
  assign y         = r_y;
  assign y_valid   = r_y_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
// Table vectors, hand sequences and random traffic against a queue-free behavioural model.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst_n;
  logic [7:0]       req;
  logic [7:0]       x;
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;
  logic             y;
  logic             y_valid;

  int n_checks;
  int n_err;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .x         (x),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt),
    .y         (y),
    .y_valid   (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: holder index (-1 = idle), hold count, last-grant pointer.
  int m_hold;
  int m_cnt;
  int m_ptr;
  int m_sel;
  int m_y;
  int m_yv;

  typedef struct {
    logic [7:0] req;
    logic [7:0] x;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic [3:0] cnt;
    logic       y;
    logic       yv;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1; m_cnt = 0; m_ptr = 7; m_sel = 0; m_y = 0; m_yv = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] d);
    int w;
    m_yv = (m_hold >= 0) ? 1 : 0;
    m_y  = (m_hold >= 0) ? int'(d[m_sel]) : 0;
    if (m_hold >= 0 && r[m_hold] && m_cnt < MAX_HOLD) begin
      m_cnt++;
    end else begin
      w = rr_pick(m_ptr, r);
      if (w >= 0) begin
        m_hold = w; m_sel = w; m_ptr = w; m_cnt = 1;
      end else begin
        m_hold = -1; m_cnt = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"},       16'(gnt),       (m_hold >= 0) ? 16'(8'd1 << m_hold) : 16'd0);
    chk({tag, ".sel"},       16'(sel),       16'(m_sel));
    chk({tag, ".gnt_valid"}, 16'(gnt_valid), (m_hold >= 0) ? 16'd1 : 16'd0);
    chk({tag, ".hold_cnt"},  16'(hold_cnt),  16'(m_cnt));
    chk({tag, ".y"},         16'(y),         16'(m_y));
    chk({tag, ".y_valid"},   16'(y_valid),   16'(m_yv));
    chk({tag, ".onehot"},    16'($onehot0(gnt)), 16'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".gnt"},       16'(gnt),       16'd0);
    chk({tag, ".sel"},       16'(sel),       16'd0);
    chk({tag, ".gnt_valid"}, 16'(gnt_valid), 16'd0);
    chk({tag, ".hold_cnt"},  16'(hold_cnt),  16'd0);
    chk({tag, ".y"},         16'(y),         16'd0);
    chk({tag, ".y_valid"},   16'(y_valid),   16'd0);
  endtask

  // Inputs applied at negedge, model advanced at posedge, outputs sampled at the next negedge.
  task automatic cycle(input logic [7:0] r, input logic [7:0] d);
    req = r;
    x   = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;

    for (int i = 0; i < 12; i++) begin
      tbl[i].req = 8'h04;
      tbl[i].x   = 8'h04;
      tbl[i].gnt = 8'h04;
      tbl[i].sel = 3'd2;
      tbl[i].cnt = 4'((i % 4) + 1);
      tbl[i].y   = (i > 0);
      tbl[i].yv  = (i > 0);
    end

    // 1: reset is immediate, even with every requester active
    rst_n = 1'b0;
    req   = 8'hFF;
    x     = 8'hFF;
    #2;
    check_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cycle(8'h00, 8'hFF);
    check_zero("reset_idle1");
    cycle(8'h00, 8'hFF);
    check_zero("reset_idle2");

    // 2: single requester, table-driven
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].req, tbl[i].x);
      chk($sformatf("tbl%0d.gnt", i),       16'(gnt),       16'(tbl[i].gnt));
      chk($sformatf("tbl%0d.sel", i),       16'(sel),       16'(tbl[i].sel));
      chk($sformatf("tbl%0d.hold_cnt", i),  16'(hold_cnt),  16'(tbl[i].cnt));
      chk($sformatf("tbl%0d.gnt_valid", i), 16'(gnt_valid), 16'd1);
      chk($sformatf("tbl%0d.y", i),         16'(y),         16'(tbl[i].y));
      chk($sformatf("tbl%0d.y_valid", i),   16'(y_valid),   16'(tbl[i].yv));
    end

    // 3: all requesting -> full rotation, 4 cycles each, no gaps
    do_reset();
    for (int n = 0; n < 36; n++) begin
      cycle(8'hFF, 8'($urandom));
      chk($sformatf("rot%0d.sel", n),      16'(sel),      16'((n / 4) % 8));
      chk($sformatf("rot%0d.hold_cnt", n), 16'(hold_cnt), 16'((n % 4) + 1));
      chk($sformatf("rot%0d.gnt", n),      16'(gnt),      16'(8'd1 << ((n / 4) % 8)));
      check_model("rot");
    end

    // 4a: wrap from 6 past 7 to 0, then back to 6
    do_reset();
    cycle(8'h40, 8'h00);
    chk("wrap.first", 16'(sel), 16'd6);
    for (int n = 0; n < 8; n++) begin
      cycle(8'h41, 8'h41);
      check_model("wrap");
      if (n == 3) chk("wrap.to0", 16'(sel), 16'd0);
      if (n == 7) chk("wrap.to6", 16'(sel), 16'd6);
    end

    // 4b: early release of requester 3 hands over to 5 at once
    do_reset();
    cycle(8'h28, 8'h08);
    cycle(8'h28, 8'h08);
    chk("early.hold3", 16'(sel), 16'd3);
    cycle(8'h20, 8'h20);
    chk("early.sel5", 16'(sel), 16'd5);
    chk("early.cnt1", 16'(hold_cnt), 16'd1);
    check_model("early");

    // 5: idle return, sel retained, y_valid falls one cycle later
    do_reset();
    cycle(8'h10, 8'h10);
    cycle(8'h10, 8'h10);
    chk("idle.gnt", 16'(gnt), 16'h10);
    cycle(8'h00, 8'h10);
    chk("idle.gnt0", 16'(gnt), 16'd0);
    chk("idle.sel4", 16'(sel), 16'd4);
    chk("idle.yv_still", 16'(y_valid), 16'd1);
    cycle(8'h00, 8'h10);
    chk("idle.yv_fall", 16'(y_valid), 16'd0);
    check_model("idle");

    // 6: asynchronous reset mid-grant, then lone requester 7
    do_reset();
    cycle(8'h20, 8'h20);
    cycle(8'h20, 8'h20);
    chk("mid.gnt", 16'(gnt), 16'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    cycle(8'h80, 8'h80);
    chk("mid.gnt7", 16'(gnt), 16'h80);
    chk("mid.sel7", 16'(sel), 16'd7);
    check_model("mid");

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'($urandom);
        default: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      endcase
      cycle(r, 8'($urandom));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
